// File: rtl/role_pix_proc.sv
// role_pix_proc: streaming per-pixel processing core.
// A two-stage pipeline with full backpressure. Stage 1 captures the beat and
// the configuration that belongs to its frame. Stage 2 holds the processed
// pixel for the output stream. A beat counter flags malformed line lengths,
// and a frame counter counts start-of-frame beats.
module role_pix_proc #(
   parameter int PIX_W    = 8,
   parameter int CH       = 3,
   parameter int LINE_LEN = 640,
   parameter int CNT_W    = 16
) (
   input  logic                role_clk,
   input  logic                role_rst_n,
   input  logic [1:0]          cfg_mode,
   input  logic [PIX_W-1:0]    cfg_param,
   input  logic [CH*PIX_W-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   input  logic                s_axis_tuser,
   output logic [CH*PIX_W-1:0] m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic                m_axis_tuser,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic                line_err,
   output logic                busy
);

   localparam int DW   = CH * PIX_W;
   localparam int LC_W = $clog2(LINE_LEN + 1);
   localparam logic [LC_W-1:0]  LINE_LEN_C = LC_W'(LINE_LEN);
   localparam logic [PIX_W-1:0] PIX_MAX    = {PIX_W{1'b1}};

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_INVERT = 2'd1;
   localparam logic [1:0] MODE_THRESH = 2'd2;
   localparam logic [1:0] MODE_SATADD = 2'd3;

   // Handshake and enable
   logic              out_en_reg;
   logic              adv1;
   logic              adv2;
   logic              accept;

   // Stage 1: captured beat plus the configuration of its frame
   logic              v1_reg;
   logic [DW-1:0]     data1_reg;
   logic              last1_reg;
   logic              user1_reg;
   logic [1:0]        mode1_reg;
   logic [PIX_W-1:0]  param1_reg;

   // Stage 2: processed beat presented downstream
   logic              v2_reg;
   logic [DW-1:0]     data2_reg;
   logic              last2_reg;
   logic              user2_reg;

   // Frame-level configuration, latched on start of frame
   logic [1:0]        shadow_mode_reg;
   logic [PIX_W-1:0]  shadow_param_reg;

   // Line-length check and frame counting
   logic [LC_W-1:0]   cnt_reg;
   logic [LC_W-1:0]   cnt_base;
   logic [LC_W-1:0]   cnt_inc;
   logic [LC_W-1:0]   cnt_next;
   logic              at_len;
   logic              bad_len;
   logic              line_err_reg;
   logic [CNT_W-1:0]  frame_cnt_reg;

   logic [DW-1:0]     result_comb;

   // A stage may take a new beat when it is empty or its contents move on.
   // out_en_reg keeps the input closed while reset is held and opens it on
   // the first clock after release.
   assign adv2          = !v2_reg | m_axis_tready;
   assign adv1          = !v1_reg | adv2;
   assign s_axis_tready = adv1 & out_en_reg;
   assign accept        = s_axis_tvalid & s_axis_tready;

   // Input enable: opens one clock after reset release
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         out_en_reg <= 1'b0;
      end else begin
         out_en_reg <= 1'b1;
      end
   end

   // Frame configuration: sampled only by an accepted start-of-frame beat
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         shadow_mode_reg  <= MODE_PASS;
         shadow_param_reg <= '0;
      end else if (accept && s_axis_tuser) begin
         shadow_mode_reg  <= cfg_mode;
         shadow_param_reg <= cfg_param;
      end
   end

   // Stage 1 register. A start-of-frame beat uses the live config,
   // because the shadow copy only updates on the same clock edge.
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         v1_reg     <= 1'b0;
         data1_reg  <= '0;
         last1_reg  <= 1'b0;
         user1_reg  <= 1'b0;
         mode1_reg  <= MODE_PASS;
         param1_reg <= '0;
      end else begin
         if (adv1) begin
            v1_reg <= accept;
         end
         if (accept) begin
            data1_reg  <= s_axis_tdata;
            last1_reg  <= s_axis_tlast;
            user1_reg  <= s_axis_tuser;
            mode1_reg  <= s_axis_tuser ? cfg_mode  : shadow_mode_reg;
            param1_reg <= s_axis_tuser ? cfg_param : shadow_param_reg;
         end
      end
   end

   // Per-channel arithmetic on the stage-1 sample
   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         logic [PIX_W-1:0] x_ch;
         logic [PIX_W:0]   sum_ch;
         logic [PIX_W-1:0] y_ch;

         assign x_ch   = data1_reg[gi*PIX_W +: PIX_W];
         assign sum_ch = {1'b0, x_ch} + {1'b0, param1_reg};

         // Select the result for this channel; the add saturates at MAX
         always_comb begin
            y_ch = x_ch;
            case (mode1_reg)
               MODE_PASS:   y_ch = x_ch;
               MODE_INVERT: y_ch = PIX_MAX - x_ch;
               MODE_THRESH: y_ch = (x_ch >= param1_reg) ? PIX_MAX : '0;
               MODE_SATADD: y_ch = sum_ch[PIX_W] ? PIX_MAX : sum_ch[PIX_W-1:0];
               default:     y_ch = x_ch;
            endcase
         end

         assign result_comb[gi*PIX_W +: PIX_W] = y_ch;
      end
   endgenerate

   // Stage 2 register: holds the result stable until the sink takes it
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         v2_reg    <= 1'b0;
         data2_reg <= '0;
         last2_reg <= 1'b0;
         user2_reg <= 1'b0;
      end else if (adv2) begin
         v2_reg <= v1_reg;
         if (v1_reg) begin
            data2_reg <= result_comb;
            last2_reg <= last1_reg;
            user2_reg <= user1_reg;
         end
      end
   end

   // A start-of-frame beat is always position 1 of its line. The line
   // closes either on tlast or on reaching LINE_LEN; a mismatch between
   // the two is a length error.
   assign cnt_base = s_axis_tuser ? '0 : cnt_reg;
   assign cnt_inc  = cnt_base + LC_W'(1);
   assign at_len   = (cnt_inc == LINE_LEN_C);
   assign bad_len  = s_axis_tlast ^ at_len;
   assign cnt_next = (s_axis_tlast || at_len) ? '0 : cnt_inc;

   // Beat position within the current line
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= cnt_next;
      end
   end

   // Length-error pulse, one cycle after the offending beat
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         line_err_reg <= 1'b0;
      end else begin
         line_err_reg <= accept & bad_len;
      end
   end

   // Frame counter; wraps naturally at its width
   always_ff @(posedge role_clk or negedge role_rst_n) begin
      if (!role_rst_n) begin
         frame_cnt_reg <= '0;
      end else if (accept && s_axis_tuser) begin
         frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
      end
   end

   assign m_axis_tdata  = data2_reg;
   assign m_axis_tvalid = v2_reg;
   assign m_axis_tlast  = last2_reg;
   assign m_axis_tuser  = user2_reg;
   assign frame_cnt     = frame_cnt_reg;
   assign line_err      = line_err_reg;
   assign busy          = v1_reg | v2_reg;

endmodule

// File: tb/tb_role_pix_proc.sv
// tb_role_pix_proc: randomized and directed stimulus for role_pix_proc.
// A frame-level reference model predicts the output stream, line errors,
// the frame count and pipeline occupancy.
module tb_role_pix_proc;

   localparam int PIX_W    = 8;
   localparam int CH       = 3;
   localparam int LINE_LEN = 8;
   localparam int CNT_W    = 2;
   localparam int DW       = CH * PIX_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       cfg_mode = 2'd0;
   logic [PIX_W-1:0] cfg_param = '0;
   logic [DW-1:0]    s_data = '0;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic             s_last = 1'b0;
   logic             s_user = 1'b0;
   logic [DW-1:0]    m_data;
   logic             m_valid;
   logic             m_ready = 1'b1;
   logic             m_last;
   logic             m_user;
   logic [CNT_W-1:0] frame_cnt;
   logic             line_err;
   logic             busy;

   role_pix_proc #(
      .PIX_W(PIX_W), .CH(CH), .LINE_LEN(LINE_LEN), .CNT_W(CNT_W)
   ) dut (
      .role_clk      (clk),
      .role_rst_n    (rst_n),
      .cfg_mode      (cfg_mode),
      .cfg_param     (cfg_param),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
      .s_axis_tlast  (s_last),
      .s_axis_tuser  (s_user),
      .m_axis_tdata  (m_data),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready),
      .m_axis_tlast  (m_last),
      .m_axis_tuser  (m_user),
      .frame_cnt     (frame_cnt),
      .line_err      (line_err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
      int            cyc;
   } beat_t;

   beat_t exp_q[$];
   int    m_mode    = 0;
   int    m_param   = 0;
   int    m_line    = 0;
   int    m_frames  = 0;
   bit    m_err     = 1'b0;
   int    cyc       = 0;
   int    since_rst = 0;
   int    err_pulses = 0;
   bit    lat_check = 1'b1;
   bit    rand_ready = 1'b0;
   bit    ready_fixed = 1'b1;

   function automatic logic [DW-1:0] ref_pix(input logic [DW-1:0] d, input int mode, input int p);
      logic [DW-1:0] r;
      int x;
      int y;
      r = '0;
      for (int k = 0; k < CH; k++) begin
         x = int'(d[k*PIX_W +: PIX_W]);
         case (mode)
            0:       y = x;
            1:       y = 255 - x;
            2:       y = (x >= p) ? 255 : 0;
            default: y = (x + p > 255) ? 255 : x + p;
         endcase
         r[k*PIX_W +: PIX_W] = 8'(y);
      end
      return r;
   endfunction

   // Output-ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
      end
   end

   // Monitor: all sampling on the falling edge
   logic [DW-1:0] prev_data;
   logic          prev_last;
   logic          prev_user;
   bit            prev_stall = 1'b0;

   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_mode = 0; m_param = 0; m_line = 0; m_frames = 0; m_err = 1'b0;
            prev_stall = 1'b0;
            since_rst = 0;
         end else begin
            cyc++;
            since_rst++;
            check_val("line_err", 32'(line_err), 32'(m_err));
            if (line_err) err_pulses++;
            check_val("frame_cnt", 32'(frame_cnt), 32'(m_frames % 4));
            check_val("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (since_rst > 2 && m_ready) check_val("full_rate_ready", 32'(s_ready), 32'd1);
            if (prev_stall) begin
               check_val("stall_valid", 32'(m_valid), 32'd1);
               check_val("stall_data", 32'(m_data), 32'(prev_data));
               check_val("stall_flags", {30'd0, m_last, m_user}, {30'd0, prev_last, prev_user});
            end
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check_val("spurious_out", 32'(m_valid), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  $display("OUT data=%06h last=%0d user=%0d exp=%06h", m_data, m_last, m_user, e.data);
                  check_val("out_data", 32'(m_data), 32'(e.data));
                  check_val("out_flags", {30'd0, m_last, m_user}, {30'd0, e.last, e.user});
                  if (lat_check) check_val("latency", 32'(cyc - e.cyc), 32'd2);
               end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_user  = m_user;
            m_err = 1'b0;
            if (s_valid && s_ready) begin
               if (s_user) begin
                  m_mode  = int'(cfg_mode);
                  m_param = int'(cfg_param);
                  m_line  = 0;
                  m_frames++;
               end
               m_line++;
               if (s_last) begin
                  m_err  = (m_line != LINE_LEN);
                  m_line = 0;
               end else if (m_line == LINE_LEN) begin
                  m_err  = 1'b1;
                  m_line = 0;
               end
               e.data = ref_pix(s_data, m_mode, m_param);
               e.last = s_last;
               e.user = s_user;
               e.cyc  = cyc;
               exp_q.push_back(e);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [DW-1:0] pix_q[$];

   task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit user);
      int t;
      t = 0;
      s_data = d; s_last = last; s_user = user; s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check_val("send_timeout", 32'(t), 32'd0);
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
   endtask

   // Sends pix_q as one line; tlast on beat last_at (1-based, 0 = none)
   task automatic send_line(input bit sof, input int last_at, input bit gaps);
      for (int i = 0; i < pix_q.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         send_beat(pix_q[i], (i + 1) == last_at, sof && (i == 0));
      end
   endtask

   task automatic rand_line(input bit sof, input int last_at, input bit gaps);
      pix_q.delete();
      for (int i = 0; i < LINE_LEN; i++) pix_q.push_back(DW'($urandom));
      send_line(sof, last_at, gaps);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_val("drain_timeout", 32'(t < 300), 32'd1);
   endtask

   initial begin
      int pulses0;
      // Reset state
      #1;
      check_val("rst_s_ready", 32'(s_ready), 32'd0);
      check_val("rst_m_valid", 32'(m_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_val("rst_line_err", 32'(line_err), 32'd0);
      check_val("rst_m_data", 32'(m_data), 32'd0);
      #27;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_val("post_rst_ready", 32'(s_ready), 32'd1);

      // Mode 0 pass-through
      cfg_mode = 2'd0; cfg_param = 8'h00;
      pix_q = '{24'h102030, 24'h203040, 24'h304050, 24'h405060,
                24'h000000, 24'hFFFFFF, 24'h0180FE, 24'h7F7F7F};
      send_line(1'b1, 8, 1'b0);
      drain();

      // Mode 3 saturating add
      cfg_mode = 2'd3; cfg_param = 8'h20;
      pix_q = '{24'hF0F0F0, 24'h101010, 24'hF01020, 24'hDFE0E1,
                24'h000000, 24'hFFFFFF, 24'h202020, 24'h7F7F7F};
      send_line(1'b1, 8, 1'b0);
      drain();

      // Mode 2 threshold; mid-frame switch to invert is ignored
      cfg_mode = 2'd2; cfg_param = 8'h80;
      pix_q = '{24'h7F7F7F, 24'h808080, 24'h7F8081, 24'h00FF80,
                24'h112233, 24'h8899AA, 24'h010203, 24'hFEFDFC};
      send_line(1'b1, 8, 1'b0);
      cfg_mode = 2'd1;
      send_line(1'b0, 8, 1'b1);
      send_line(1'b1, 8, 1'b0);
      drain();

      // Random backpressure across three lines, then full rate
      lat_check = 1'b0;
      rand_ready = 1'b1;
      cfg_mode = 2'($urandom); cfg_param = 8'($urandom);
      rand_line(1'b1, 8, 1'b1);
      cfg_mode = 2'($urandom); cfg_param = 8'($urandom);
      rand_line(1'b0, 8, 1'b1);
      rand_line(1'b0, 8, 1'b1);
      drain();
      rand_ready = 1'b0;
      ready_fixed = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lat_check = 1'b1;
      cfg_mode = 2'd3; cfg_param = 8'($urandom);
      rand_line(1'b1, 8, 1'b0);
      rand_line(1'b0, 8, 1'b0);
      drain();

      // Line-length errors: early tlast, then missing tlast, then a clean line
      pulses0 = err_pulses;
      cfg_mode = 2'd0;
      pix_q.delete();
      for (int i = 0; i < 5; i++) pix_q.push_back(DW'($urandom));
      send_line(1'b1, 5, 1'b0);
      rand_line(1'b0, 0, 1'b0);
      rand_line(1'b0, 8, 1'b0);
      drain();
      repeat (2) @(posedge clk);
      #1;
      check_val("line_err_pulses", 32'(err_pulses - pulses0), 32'd2);

      // Reset with both stages full and the output stalled
      ready_fixed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      lat_check = 1'b0;
      cfg_mode = 2'd1;
      send_beat(24'hA1B2C3, 1'b0, 1'b1);
      send_beat(24'h445566, 1'b0, 1'b0);
      check_val("stall_full_ready", 32'(s_ready), 32'd0);
      check_val("stall_full_busy", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_m_valid", 32'(m_valid), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check_val("mid_rst_ready", 32'(s_ready), 32'd0);
      ready_fixed = 1'b1;
      cfg_mode = 2'd0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rerst_ready", 32'(s_ready), 32'd1);
      lat_check = 1'b1;

      // Fresh frames in mode 0; frame counter wraps at 2 bits
      for (int f = 0; f < 3; f++) rand_line(1'b1, 8, 1'b0);
      drain();
      check_val("frame_cnt_3", 32'(frame_cnt), 32'd3);
      for (int f = 0; f < 2; f++) rand_line(1'b1, 8, 1'b0);
      drain();
      check_val("frame_cnt_5", 32'(frame_cnt), 32'd1);

      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
